blink_sequencer: RTL and testbench
==================================

Name: blink_sequencer

Overview:
- AXI4-Lite write-only master that configures the LED blink-rate slave. It steps through a small table of per-LED divisor patterns.
- Each step writes one 32-bit divisor to each LED register. It then holds for a programmable number of cycles, advances, and wraps.
- Sits beside the CPU-side interconnect port and drives the blink slave's S_AXI write channels.
- Patterns are loaded over a simple config port.

Parameters:
- LED_COUNT, 4, number of LED registers written per step (register i at BASE_ADDR + 4*i).
- STEPS, 8, depth of pattern table; must be a power of 2, max 16.
- BASE_ADDR, 32'h0, AXI address of LED register 0.
- DIV_W, 8, width of a stored divisor (zero-extended to 32 bits on WDATA).

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: begin sequencing at step 0 (ignored while busy)
- stop  in  1  pulse: finish current AXI write, then go idle
- num_steps  in  log2(STEPS)+1  active steps; 0 or >STEPS means STEPS
- hold_cycles  in  32  cycles to dwell after a step's last write completes
- cfg_we  in  1  write pattern entry
- cfg_step  in  log2(STEPS)  entry step index
- cfg_led  in  log2(LED_COUNT)  entry LED index
- cfg_div  in  DIV_W  divisor value (0=off, >20=on, 1..20=blink rate)
- busy  out  1  sequencer not idle
- cur_step  out  log2(STEPS)  step currently being written/held
- error  out  1  sticky: non-OKAY BRESP seen; cleared by start or reset
- M_AXI_AWADDR out 32, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, M_AXI_AWPROT out 3 (tied 0)
- M_AXI_WDATA out 32, M_AXI_WSTRB out 4 (tied 4'hF), M_AXI_WVALID out 1, M_AXI_WREADY in 1
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1

Behaviour:
- Reset values: busy=0, cur_step=0, error=0, AWVALID=0, WVALID=0, BREADY=0, AWADDR=0, WDATA=0. Pattern table is not reset.
- A reset mid-transaction drops all valids in the same clock edge.
- Pattern table: STEPS x LED_COUNT x DIV_W registers.
  - cfg_we writes on the clock edge and is allowed at any time.
  - An entry written while busy takes effect the next time that entry is fetched.
- FSM states: IDLE, ISSUE, RESP, HOLD.
  - IDLE: on start → clear error, step=0, led=0, enter ISSUE. busy=1 in every state except IDLE.
  - ISSUE: AWADDR=BASE_ADDR+4*led and WDATA=zero-extended table[step][led] are loaded on entry. AWVALID and WVALID both assert the cycle after entry. Each valid drops independently on its own handshake (VALID&READY). Once both channels have completed, BREADY=1 and go to RESP. AW and W may complete in either order or together.
  - RESP: on BVALID&BREADY → BREADY=0.
    - If BRESP!=0: error=1, go IDLE.
    - Else if stop is pending: go IDLE.
    - Else if led<LED_COUNT-1: led+1, go ISSUE.
    - Else: load the hold counter with hold_cycles, go HOLD.
  - HOLD: counter decrements each cycle; at 0, step=(step+1) mod effective num_steps, led=0, go ISSUE.
    - hold_cycles=0 → HOLD lasts exactly one cycle.
    - stop in HOLD → IDLE on the next edge.
- stop is latched as pending in any non-IDLE state and is cleared on entering IDLE. An AXI transaction is never abandoned mid-flight.
- start while busy is ignored. start and stop asserted together in IDLE: stop wins, stay IDLE.
- Latency: start → AWVALID asserted on cycle 2. Zero-wait slave: a step of N LEDs takes N*(handshake+B) cycles plus hold.
- cur_step updates only when ISSUE is entered for led 0.
- Width rules:
  - Address arithmetic is 32-bit, wrapping.
  - num_steps is evaluated at each step wrap, so a change takes effect on the next wrap.
  - A cur_step already ≥ a newly reduced num_steps wraps to 0.

Decomposition:
- Shared package holds the AXI response codes (OKAY=0, SLVERR=2, DECERR=3), the FSM state encoding, and the WSTRB/PROT constants.
- One sub-module is natural: blink_axi_wr_master. It implements the single-beat AW/W/B handshake with independent valid drop and returns done/bresp.
- The top-level keeps the table, step/LED counters and hold timer.

Test Plan:
- Load step0 = {1,2,0,21}, step1 = {5,5,5,5}, num_steps=2, hold_cycles=10, zero-wait slave, start → writes to 0x0,0x4,0x8,0xC with data 1,2,0,21, then 10+ cycle gap, then 5,5,5,5 four times, then wrap back to step0.
- Slave AWREADY delayed 3 cycles and WREADY immediate (then reversed) → WVALID drops first (then AWVALID), BREADY asserts only after both handshakes complete, one B per write.
- Slave returns BRESP=3 on the LED2 write → error=1, busy=0 the next cycle, no write to 0xC. A subsequent start clears error.
- stop pulsed while waiting BVALID (held off 5 cycles) → BREADY held until BVALID, then IDLE with no further AW. stop pulsed in HOLD → IDLE the next cycle.
- reset asserted with AWVALID=1 → AWVALID, WVALID, BREADY and busy all 0 after that edge. start after reset begins at step 0.
- hold_cycles=0 and num_steps=0 → back-to-back steps with a one-cycle HOLD, sequence covers all 8 steps before wrapping.

Source files
------------

// File: rtl/blink_sequencer_pkg.sv
// blink_sequencer_pkg: AXI response codes, sequencer FSM encoding and fixed write attributes
package blink_sequencer_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_HOLD} state_e;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [3:0] WSTRB_ALL   = 4'hF;
  localparam logic [2:0] PROT_NONE   = 3'd0;
endpackage

// File: rtl/blink_axi_wr_master.sv
// blink_axi_wr_master: single-beat AXI4-Lite write, AW and W valids drop independently
module blink_axi_wr_master (
  input  logic       clk,
  input  logic       reset,
  input  logic       go_i,
  input  logic       awready_i,
  input  logic       wready_i,
  input  logic       bvalid_i,
  input  logic [1:0] bresp_i,
  output logic       awvalid_o,
  output logic       wvalid_o,
  output logic       bready_o,
  output logic       addr_done_o,
  output logic       done_o,
  output logic [1:0] bresp_o
);
  logic active_q, aw_q, w_q, awd_q, wd_q, br_q;
  logic active_d, aw_d, w_d, awd_d, wd_d, br_d;
  logic launch, aw_hs, w_hs;
  assign launch = go_i & ~active_q;
  assign aw_hs = aw_q & awready_i;
  assign w_hs = w_q & wready_i;
  // high in the cycle whose edge completes the later of the two address/data handshakes
  assign addr_done_o = active_q & ~br_q & (awd_q | aw_hs) & (wd_q | w_hs);
  assign done_o = br_q & bvalid_i;
  assign bresp_o = bresp_i;
  assign awvalid_o = aw_q;
  assign wvalid_o = w_q;
  assign bready_o = br_q;
  always_comb begin
    active_d = launch | (active_q & ~done_o);
    aw_d = launch | (aw_q & ~awready_i);
    w_d = launch | (w_q & ~wready_i);
    awd_d = ~launch & (awd_q | aw_hs);
    wd_d = ~launch & (wd_q | w_hs);
    br_d = addr_done_o | (br_q & ~bvalid_i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      aw_q <= 1'b0;
      w_q <= 1'b0;
      awd_q <= 1'b0;
      wd_q <= 1'b0;
      br_q <= 1'b0;
    end else begin
      active_q <= active_d;
      aw_q <= aw_d;
      w_q <= w_d;
      awd_q <= awd_d;
      wd_q <= wd_d;
      br_q <= br_d;
    end
  end
endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: AXI4-Lite master stepping a divisor pattern table into the LED blink slave
module blink_sequencer
  import blink_sequencer_pkg::*;
#(
  parameter int          LED_COUNT = 4,
  parameter int          STEPS     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DIV_W     = 8,
  localparam int         SW        = (STEPS > 1) ? $clog2(STEPS) : 1,
  localparam int         LW        = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [SW:0]      num_steps,
  input  logic [31:0]      hold_cycles,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_step,
  input  logic [LW-1:0]    cfg_led,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             busy,
  output logic [SW-1:0]    cur_step,
  output logic             error,
  output logic [31:0]      M_AXI_AWADDR,
  output logic             M_AXI_AWVALID,
  input  logic             M_AXI_AWREADY,
  output logic [2:0]       M_AXI_AWPROT,
  output logic [31:0]      M_AXI_WDATA,
  output logic [3:0]       M_AXI_WSTRB,
  output logic             M_AXI_WVALID,
  input  logic             M_AXI_WREADY,
  input  logic [1:0]       M_AXI_BRESP,
  input  logic             M_AXI_BVALID,
  output logic             M_AXI_BREADY
);
  localparam logic [SW:0]   NS_MAX   = (SW + 1)'(STEPS);
  localparam logic [LW-1:0] LED_LAST = LW'(LED_COUNT - 1);
  logic [DIV_W-1:0] tbl_q [STEPS][LED_COUNT];
  state_e state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [LW-1:0] led_q, led_d;
  logic [31:0] hold_q, hold_d, addr_q, addr_d, wdata_q, wdata_d;
  logic error_q, error_d, stop_q, stop_d;
  logic [SW:0] eff_steps, step_inc;
  logic stop_now, addr_done, done;
  logic [1:0] bresp;
  assign stop_now = stop_q | stop;
  assign eff_steps = (num_steps == '0 || num_steps > NS_MAX) ? NS_MAX : num_steps;
  assign step_inc = {1'b0, step_q} + (SW + 1)'(1);
  always_ff @(posedge clk)
    if (cfg_we) tbl_q[cfg_step][cfg_led] <= cfg_div;
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    led_d = led_q;
    hold_d = hold_q;
    error_d = error_q;
    stop_d = stop_q | (stop & (state_q != S_IDLE));
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE:
        if (start && !stop) begin
          state_d = S_ISSUE;
          error_d = 1'b0;
          step_d = '0;
          led_d = '0;
        end
      S_ISSUE: state_d = addr_done ? S_RESP : S_ISSUE;
      S_RESP:
        if (done) begin
          if (bresp != RESP_OKAY) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else if (stop_now) state_d = S_IDLE;
          else if (led_q != LED_LAST) begin
            led_d = led_q + LW'(1);
            state_d = S_ISSUE;
          end else begin
            hold_d = hold_cycles;
            state_d = S_HOLD;
          end
        end
      S_HOLD:
        if (stop_now) state_d = S_IDLE;
        else if (hold_q == '0) begin
          state_d = S_ISSUE;
          // compare before truncating so a step beyond a shrunken num_steps wraps to 0
          step_d = (step_inc >= eff_steps) ? '0 : step_inc[SW-1:0];
          led_d = '0;
        end else hold_d = hold_q - 32'd1;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) stop_d = 1'b0;
    if (state_d == S_ISSUE && state_q != S_ISSUE) begin
      addr_d = BASE_ADDR + 32'({led_d, 2'b00});
      wdata_d = 32'(tbl_q[step_d][led_d]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q <= '0;
      led_q <= '0;
      hold_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      led_q <= led_d;
      hold_q <= hold_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
      stop_q <= stop_d;
    end
  end
  blink_axi_wr_master u_wr (
    .clk(clk),
    .reset(reset),
    .go_i(state_q == S_ISSUE),
    .awready_i(M_AXI_AWREADY),
    .wready_i(M_AXI_WREADY),
    .bvalid_i(M_AXI_BVALID),
    .bresp_i(M_AXI_BRESP),
    .awvalid_o(M_AXI_AWVALID),
    .wvalid_o(M_AXI_WVALID),
    .bready_o(M_AXI_BREADY),
    .addr_done_o(addr_done),
    .done_o(done),
    .bresp_o(bresp)
  );
  assign busy = state_q != S_IDLE;
  assign cur_step = step_q;
  assign error = error_q;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_WDATA = wdata_q;
  assign M_AXI_AWPROT = PROT_NONE;
  assign M_AXI_WSTRB = WSTRB_ALL;
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: directed checks of the blink pattern sequencer against a configurable AXI slave
module tb_blink_sequencer;
  logic clk = 1'b0, reset, start, stop, cfg_we;
  logic [3:0] num_steps;
  logic [31:0] hold_cycles;
  logic [2:0] cfg_step, cur_step;
  logic [1:0] cfg_led, M_AXI_BRESP;
  logic [7:0] cfg_div;
  logic busy, error;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA;
  logic M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID;
  logic [2:0] M_AXI_AWPROT;
  logic [3:0] M_AXI_WSTRB;
  int n_cmp = 0, n_fail = 0;
  int aw_delay, w_delay, b_delay, err_en;
  logic [31:0] err_addr, last_aw;
  logic [31:0] aw_q[$], w_q[$];
  int st_q[$], aw_cyc_q[$];
  int cyc = 0, aw_cyc = 0, w_cyc = 0, br_cyc = 0, b_cnt = 0;
  logic br_prev = 1'b0;
  int aw_cnt = 0, w_cnt = 0, b_wait = 0;
  int a0, w0, b0;
  int t1_data[12];
  blink_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .num_steps(num_steps),
    .hold_cycles(hold_cycles), .cfg_we(cfg_we), .cfg_step(cfg_step), .cfg_led(cfg_led),
    .cfg_div(cfg_div), .busy(busy), .cur_step(cur_step), .error(error),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
  );
  always #5 clk = ~clk;
  // monitor: logs handshakes as seen on the rising edge
  always @(posedge clk) begin
    if (M_AXI_AWVALID && M_AXI_AWREADY) begin
      aw_q.push_back(M_AXI_AWADDR);
      st_q.push_back(int'(cur_step));
      aw_cyc_q.push_back(cyc);
      last_aw <= M_AXI_AWADDR;
      aw_cyc <= cyc;
    end
    if (M_AXI_WVALID && M_AXI_WREADY) begin
      w_q.push_back(M_AXI_WDATA);
      w_cyc <= cyc;
    end
    if (M_AXI_BVALID && M_AXI_BREADY) b_cnt <= b_cnt + 1;
    if (M_AXI_BREADY && !br_prev) br_cyc <= cyc;
    br_prev <= M_AXI_BREADY;
    cyc <= cyc + 1;
  end
  // slave: readies/response driven on the falling edge after per-channel delays
  always @(negedge clk) begin
    if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
    else begin M_AXI_AWREADY = 1'b0; aw_cnt = 0; end
    if (M_AXI_WVALID) begin M_AXI_WREADY = (w_cnt >= w_delay); w_cnt++; end
    else begin M_AXI_WREADY = 1'b0; w_cnt = 0; end
    if (M_AXI_BREADY) begin
      M_AXI_BVALID = (b_wait >= b_delay);
      M_AXI_BRESP = (err_en != 0 && last_aw == err_addr) ? 2'd3 : 2'd0;
      b_wait++;
    end else begin M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'd0; b_wait = 0; end
  end
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input int s, input int l, input int d);
    cfg_we = 1'b1; cfg_step = 3'(s); cfg_led = 2'(l); cfg_div = 8'(d);
    tick(1);
    cfg_we = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask
  task automatic stop_and_idle(input string tag);
    stop = 1'b1; tick(1); stop = 1'b0;
    for (int i = 0; i < 60 && busy; i++) tick(1);
    chk(tag, busy, 0);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; num_steps = 4'd0; hold_cycles = 0;
    cfg_we = 1'b0; cfg_step = 0; cfg_led = 0; cfg_div = 0;
    aw_delay = 0; w_delay = 0; b_delay = 0; err_en = 0; err_addr = 0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'd0;
    t1_data = '{1, 2, 0, 21, 5, 5, 5, 5, 1, 2, 0, 21};
    tick(2);
    cfg(0, 0, 1); cfg(0, 1, 2); cfg(0, 2, 0); cfg(0, 3, 21);
    for (int l = 0; l < 4; l++) cfg(1, l, 5);
    reset = 1'b0;
    tick(1);
    chk("rst_busy", busy, 0); chk("rst_step", cur_step, 0); chk("rst_error", error, 0);
    chk("rst_awvalid", M_AXI_AWVALID, 0); chk("rst_wvalid", M_AXI_WVALID, 0);
    chk("rst_bready", M_AXI_BREADY, 0); chk("rst_awaddr", M_AXI_AWADDR, 0);
    chk("rst_wdata", M_AXI_WDATA, 0);
    chk("wstrb", M_AXI_WSTRB, 4'hF); chk("awprot", M_AXI_AWPROT, 0);
    // two-step pattern, zero-wait slave
    num_steps = 4'd2; hold_cycles = 10; a0 = aw_q.size(); w0 = w_q.size();
    pulse_start();
    chk("lat_c1_awvalid", M_AXI_AWVALID, 0);
    tick(1);
    chk("lat_c2_awvalid", M_AXI_AWVALID, 1); chk("lat_awaddr", M_AXI_AWADDR, 0);
    chk("lat_wdata", M_AXI_WDATA, 1); chk("lat_busy", busy, 1);
    for (int i = 0; i < 300 && aw_q.size() < a0 + 12; i++) tick(1);
    chk("t1_count", aw_q.size() >= a0 + 12, 1);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t1_addr%0d", k), aw_q[a0 + k], 32'(4 * (k % 4)));
      chk($sformatf("t1_data%0d", k), w_q[w0 + k], 32'(t1_data[k]));
      chk($sformatf("t1_step%0d", k), st_q[a0 + k], 32'((k / 4) % 2));
    end
    chk("t1_led_gap", aw_cyc_q[a0 + 1] - aw_cyc_q[a0], 3);
    chk("t1_hold_gap", aw_cyc_q[a0 + 4] - aw_cyc_q[a0 + 3], 14);
    stop_and_idle("t1_idle");
    chk("t1_error", error, 0);
    // AW held off 3 cycles, stop pending so only one write
    hold_cycles = 0; aw_delay = 3; a0 = aw_q.size(); b0 = b_cnt;
    pulse_start();
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(1);
    chk("awslow_awvalid", M_AXI_AWVALID, 1); chk("awslow_wvalid", M_AXI_WVALID, 0);
    chk("awslow_bready", M_AXI_BREADY, 0);
    for (int i = 0; i < 60 && busy; i++) tick(1);
    chk("awslow_idle", busy, 0); chk("awslow_nwr", aw_q.size() - a0, 1);
    chk("awslow_nb", b_cnt - b0, 1);
    chk("awslow_order", aw_cyc - w_cyc, 3); chk("awslow_bready_at", br_cyc - aw_cyc, 1);
    // W held off 3 cycles
    aw_delay = 0; w_delay = 3; a0 = aw_q.size(); b0 = b_cnt;
    pulse_start();
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(1);
    chk("wslow_awvalid", M_AXI_AWVALID, 0); chk("wslow_wvalid", M_AXI_WVALID, 1);
    for (int i = 0; i < 60 && busy; i++) tick(1);
    chk("wslow_idle", busy, 0); chk("wslow_nwr", aw_q.size() - a0, 1);
    chk("wslow_nb", b_cnt - b0, 1);
    chk("wslow_order", w_cyc - aw_cyc, 3); chk("wslow_bready_at", br_cyc - w_cyc, 1);
    // DECERR on LED2 aborts the step
    w_delay = 0; err_en = 1; err_addr = 32'h8; hold_cycles = 10; a0 = aw_q.size();
    pulse_start();
    for (int i = 0; i < 100 && !(M_AXI_BVALID && M_AXI_BREADY && M_AXI_BRESP == 2'd3); i++) tick(1);
    chk("err_seen", M_AXI_BVALID && M_AXI_BREADY && M_AXI_BRESP == 2'd3, 1);
    tick(1);
    chk("err_busy", busy, 0); chk("err_flag", error, 1);
    tick(20);
    chk("err_nwr", aw_q.size() - a0, 3); chk("err_last", aw_q[a0 + 2], 32'h8);
    chk("err_sticky", error, 1);
    err_en = 0;
    pulse_start();
    chk("err_clr", error, 0); chk("err_restart", busy, 1);
    stop_and_idle("err_idle");
    // stop while BVALID is held off
    b_delay = 5; a0 = aw_q.size(); b0 = b_cnt;
    pulse_start();
    for (int i = 0; i < 50 && !M_AXI_BREADY; i++) tick(1);
    chk("bwait_bready", M_AXI_BREADY, 1);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("bwait_hold", M_AXI_BREADY, 1); chk("bwait_busy", busy, 1);
    for (int i = 0; i < 50 && busy; i++) tick(1);
    chk("bwait_idle", busy, 0);
    tick(10);
    chk("bwait_nwr", aw_q.size() - a0, 1); chk("bwait_nb", b_cnt - b0, 1);
    // stop during HOLD
    b_delay = 0; hold_cycles = 20; a0 = aw_q.size(); b0 = b_cnt;
    pulse_start();
    for (int i = 0; i < 100 && b_cnt < b0 + 4; i++) tick(1);
    chk("hstop_nwr", aw_q.size() - a0, 4);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("hstop_busy", busy, 0);
    tick(25);
    chk("hstop_after", aw_q.size() - a0, 4);
    // reset with AWVALID pending in step 1
    hold_cycles = 0;
    pulse_start();
    for (int i = 0; i < 100 && cur_step != 3'd1; i++) tick(1);
    chk("rmid_step1", cur_step, 1);
    aw_delay = 5;
    for (int i = 0; i < 20 && !M_AXI_AWVALID; i++) tick(1);
    chk("rmid_awvalid", M_AXI_AWVALID, 1);
    reset = 1'b1; tick(1);
    chk("rmid_aw", M_AXI_AWVALID, 0); chk("rmid_w", M_AXI_WVALID, 0);
    chk("rmid_b", M_AXI_BREADY, 0); chk("rmid_busy", busy, 0);
    chk("rmid_wdata", M_AXI_WDATA, 0); chk("rmid_curstep", cur_step, 0);
    reset = 1'b0; aw_delay = 0; a0 = aw_q.size();
    pulse_start();
    for (int i = 0; i < 20 && aw_q.size() <= a0; i++) tick(1);
    chk("rmid_addr", aw_q[a0], 0); chk("rmid_st", st_q[a0], 0);
    stop_and_idle("rmid_idle");
    // num_steps=0 covers all 8 steps, one-cycle HOLD
    num_steps = 4'd0;
    for (int s = 0; s < 8; s++) cfg(s, 0, 30 + s);
    a0 = aw_q.size(); w0 = w_q.size();
    pulse_start();
    for (int i = 0; i < 600 && aw_q.size() < a0 + 36; i++) tick(1);
    chk("all_count", aw_q.size() >= a0 + 36, 1);
    for (int s = 0; s < 9; s++) begin
      chk($sformatf("all_data%0d", s), w_q[w0 + 4 * s], 32'(30 + s % 8));
      chk($sformatf("all_step%0d", s), st_q[a0 + 4 * s], 32'(s % 8));
    end
    chk("all_gap", aw_cyc_q[a0 + 4] - aw_cyc_q[a0 + 3], 4);
    stop_and_idle("all_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
